// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 bus bundle between a master agent and the ei_axi4_slave_mem responder.
// Carries the five channels (AW, W, B, AR, R) with a burst-only subset of AXI4.
interface ei_axi4_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave responder backed by a word-addressed memory.
// Independent write and read engines, one outstanding burst each, FIXED/INCR/WRAP
// bursts of full-width beats. Out-of-range beats and malformed bursts answer SLVERR
// and never touch memory. Memory contents are deliberately not reset.
module ei_axi4_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic               aclk,
    input  logic               aresetn,
    ei_axi4_slave_mem_if.slave axi
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // ------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~(BYTES_A - ONE_A);
    endfunction

    // Reserved burst type, or WRAP with an illegal length or unaligned start.
    function automatic logic burst_is_err(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [7:0]            len,
                                          input logic [1:0]            burst);
        logic err;
        case (burst)
            BURST_WRAP: err = ((len != 8'd1) && (len != 8'd3) && (len != 8'd7) && (len != 8'd15))
                              || ((addr & (BYTES_A - ONE_A)) != '0);
            BURST_RSVD: err = 1'b1;
            default:    err = 1'b0;
        endcase
        return err;
    endfunction

    // Address of the beat following 'addr' within the burst.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] win;
        logic [ADDR_WIDTH-1:0] lower;
        logic [ADDR_WIDTH-1:0] sum;
        logic [ADDR_WIDTH-1:0] nxt;
        win   = (ADDR_WIDTH'(len) + ONE_A) << ADDR_LSB;
        lower = addr & ~(win - ONE_A);
        sum   = addr + BYTES_A;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (sum == (lower + win)) ? lower : sum;
            default:     nxt = sum;
        endcase
        return nxt;
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> ADDR_LSB) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> ADDR_LSB;
        return off[IDX_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q,   waddr_d;
    logic [7:0]            wlen_q,    wlen_d;
    logic [1:0]            wburst_q,  wburst_d;
    logic [7:0]            wbeat_q,   wbeat_d;
    logic                  werr_q,    werr_d;
    logic                  wberr_q,   wberr_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  mem_we_s;
    logic                  beat_err_s;
    logic [IDX_W-1:0]      w_idx_s;

    assign w_idx_s = word_index(waddr_q);

    // Write FSM next state, beat bookkeeping and channel outputs
    always_comb begin
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        wberr_d    = wberr_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mem_we_s   = 1'b0;
        beat_err_s = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi.awvalid && awready_q) begin
                    waddr_d   = align_addr(axi.awaddr);
                    wlen_d    = axi.awlen;
                    wburst_d  = axi.awburst;
                    wberr_d   = burst_is_err(axi.awaddr, axi.awlen, axi.awburst);
                    wbeat_d   = 8'd0;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (axi.wvalid && wready_q) begin
                    mem_we_s   = addr_in_range(waddr_q) && !wberr_q;
                    beat_err_s = !addr_in_range(waddr_q) || wberr_q
                                 || (axi.wlast != (wbeat_q == wlen_q));
                    werr_d     = werr_q || beat_err_s;
                    waddr_d    = next_addr(waddr_q, wlen_q, wburst_q);
                    wbeat_d    = wbeat_q + 8'd1;
                    // A missing wlast still terminates after the 256th beat.
                    if (axi.wlast || (wbeat_q == 8'hFF)) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (axi.bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                bresp_d   = RESP_OKAY;
            end
        endcase
    end

    // Write FSM state and registered write-channel outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wburst_q  <= 2'b00;
            wbeat_q   <= 8'd0;
            werr_q    <= 1'b0;
            wberr_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            wberr_q   <= wberr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-enabled memory write; contents intentionally survive reset
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.wstrb[b]) begin
                    mem_q[w_idx_s][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q,   raddr_d;
    logic [7:0]            rlen_q,    rlen_d;
    logic [1:0]            rburst_q,  rburst_d;
    logic [7:0]            rbeat_q,   rbeat_d;
    logic                  rberr_q,   rberr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  rlast_q,   rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  rd_berr_s;
    logic                  rd_ok_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [1:0]            rd_resp_s;

    // Lookup of the beat to be loaded next: beat 0 from the AR request, later beats from raddr_q
    always_comb begin
        if (r_state_q == R_IDLE) begin
            rd_addr_s = align_addr(axi.araddr);
            rd_berr_s = burst_is_err(axi.araddr, axi.arlen, axi.arburst);
        end else begin
            rd_addr_s = raddr_q;
            rd_berr_s = rberr_q;
        end
        rd_ok_s   = addr_in_range(rd_addr_s) && !rd_berr_s;
        rd_idx_s  = rd_ok_s ? word_index(rd_addr_s) : '0;
        rd_word_s = rd_ok_s ? mem_q[rd_idx_s] : '0;
        rd_resp_s = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
    end

    // Read FSM next state and R-channel beat loading
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rberr_d   = rberr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi.arvalid && arready_q) begin
                    raddr_d   = next_addr(rd_addr_s, axi.arlen, axi.arburst);
                    rlen_d    = axi.arlen;
                    rburst_d  = axi.arburst;
                    rberr_d   = rd_berr_s;
                    rbeat_d   = 8'd0;
                    rdata_d   = rd_word_s;
                    rresp_d   = rd_resp_s;
                    rlast_d   = (axi.arlen == 8'd0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rvalid_q && axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        // Next beat loads on the accepting edge, so no bubble.
                        rdata_d   = rd_word_s;
                        rresp_d   = rd_resp_s;
                        rlast_d   = ((rbeat_q + 8'd1) == rlen_q);
                        raddr_d   = next_addr(raddr_q, rlen_q, rburst_q);
                        rbeat_d   = rbeat_q + 8'd1;
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // Read FSM state and registered read-channel outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rburst_q  <= 2'b00;
            rbeat_q   <= 8'd0;
            rberr_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rberr_q   <= rberr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed self-checking bench for ei_axi4_slave_mem (32-bit data, 1024 words, base 0).
module tb_ei_axi4_slave_mem;

    localparam int AW = 32;
    localparam int DW = 32;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    ei_axi4_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

    ei_axi4_slave_mem #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (1024),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .axi    (axi_if)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [1:0]  b_resp;

    // Drives AW, then W beats 0..last_at (wlast on last_at), then collects B.
    // With stop_at >= 0 it returns after stop_at accepted beats, leaving beat stop_at offered.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int last_at,
                               input bit stall, input int stop_at);
        int n;
        bit hs;
        bit b_stalled;
        logic [1:0] b_held;
        axi_if.awaddr  = addr;
        axi_if.awlen   = len;
        axi_if.awburst = burst;
        axi_if.awvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            hs = axi_if.awready;
            @(posedge aclk); #1; n++;
        end
        axi_if.awvalid = 1'b0;
        total++;
        if (!hs) begin bad++; $display("FAIL aw_handshake got=timeout exp=accepted"); end
        for (int i = 0; i <= last_at; i++) begin
            axi_if.wdata  = wr_data[i];
            axi_if.wstrb  = wr_strb[i];
            axi_if.wlast  = (i == last_at);
            axi_if.wvalid = 1'b1;
            if (i == stop_at) return;
            n = 0; hs = 1'b0;
            while (!hs && n < 50) begin
                hs = axi_if.wready;
                @(posedge aclk); #1; n++;
            end
            total++;
            if (!hs) begin bad++; $display("FAIL w_handshake beat=%0d got=timeout exp=accepted", i); end
        end
        axi_if.wvalid = 1'b0;
        axi_if.wlast  = 1'b0;
        n = 0; hs = 1'b0; b_stalled = 1'b0; b_held = 2'b00; b_resp = 2'bxx;
        while (!hs && n < 100) begin
            axi_if.bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_stalled) begin
                total++;
                if (axi_if.bvalid !== 1'b1 || axi_if.bresp !== b_held) begin
                    bad++;
                    $display("FAIL b_stable got=%b/%b exp=1/%b", axi_if.bvalid, axi_if.bresp, b_held);
                end
            end
            hs = axi_if.bvalid && axi_if.bready;
            if (hs) begin
                b_resp = axi_if.bresp;
            end else if (axi_if.bvalid) begin
                b_stalled = 1'b1;
                b_held    = axi_if.bresp;
            end
            @(posedge aclk); #1; n++;
        end
        axi_if.bready = 1'b0;
        total++;
        if (!hs) begin bad++; $display("FAIL b_handshake got=timeout exp=accepted"); end
    endtask

    // Issues AR and collects len+1 beats into rd_data/rd_resp/rd_last.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input bit stall);
        int n;
        int k;
        bit hs;
        bit stalled;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic        s_last;
        axi_if.araddr  = addr;
        axi_if.arlen   = len;
        axi_if.arburst = burst;
        axi_if.arvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            hs = axi_if.arready;
            @(posedge aclk); #1; n++;
        end
        axi_if.arvalid = 1'b0;
        total++;
        if (!hs) begin bad++; $display("FAIL ar_handshake got=timeout exp=accepted"); end
        n = 0; k = 0; stalled = 1'b0;
        s_data = 32'h0; s_resp = 2'b00; s_last = 1'b0;
        while (k <= int'(len) && n < 300) begin
            axi_if.rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                total++;
                if (axi_if.rvalid !== 1'b1 || axi_if.rdata !== s_data ||
                    axi_if.rresp !== s_resp || axi_if.rlast !== s_last) begin
                    bad++;
                    $display("FAIL r_stable got=%b/%h/%b/%b exp=1/%h/%b/%b", axi_if.rvalid,
                             axi_if.rdata, axi_if.rresp, axi_if.rlast, s_data, s_resp, s_last);
                end
            end
            if (axi_if.rvalid && axi_if.rready) begin
                rd_data[k] = axi_if.rdata;
                rd_resp[k] = axi_if.rresp;
                rd_last[k] = axi_if.rlast;
                k++;
                stalled = 1'b0;
            end else if (axi_if.rvalid) begin
                stalled = 1'b1;
                s_data  = axi_if.rdata;
                s_resp  = axi_if.rresp;
                s_last  = axi_if.rlast;
            end else begin
                stalled = 1'b0;
            end
            @(posedge aclk); #1; n++;
        end
        axi_if.rready = 1'b0;
        total++;
        if (k != int'(len) + 1) begin bad++; $display("FAIL r_beats got=%0d exp=%0d", k, int'(len) + 1); end
        total++;
        if (axi_if.rvalid !== 1'b0) begin bad++; $display("FAIL r_after_last got=%b exp=0", axi_if.rvalid); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if ({axi_if.awready, axi_if.wready, axi_if.bvalid, axi_if.arready, axi_if.rvalid,
             axi_if.rlast, axi_if.bresp, axi_if.rresp, axi_if.rdata} !== 42'h0) begin
            bad++; $display("FAIL reset_outputs got=nonzero exp=all_zero");
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        total++;
        if ({axi_if.awready, axi_if.arready} !== 2'b00) begin
            bad++; $display("FAIL ready_before_edge got=%b exp=00", {axi_if.awready, axi_if.arready});
        end
        @(posedge aclk); #1;
        total++;
        if ({axi_if.awready, axi_if.arready} !== 2'b11) begin
            bad++; $display("FAIL ready_after_edge got=%b exp=11", {axi_if.awready, axi_if.arready});
        end
    endtask

    task automatic test_incr();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin wr_data[i] = exp_d[i]; wr_strb[i] = 4'hF; end
        write_burst(32'h10, 8'd3, 2'b01, 3, 1'b0, -1);
        total++;
        if (b_resp !== 2'b00) begin bad++; $display("FAIL incr_bresp got=%b exp=00", b_resp); end
        read_burst(32'h10, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== exp_d[i] || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL incr_rbeat[%0d] got=%h/%b/%b exp=%h/00/%b", i, rd_data[i],
                         rd_resp[i], rd_last[i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_strobe();
        wr_data[0] = 32'hAABB_CCDD; wr_strb[0] = 4'hF;
        write_burst(32'h20, 8'd0, 2'b01, 0, 1'b0, -1);
        wr_data[0] = 32'h0000_1234; wr_strb[0] = 4'h3;
        write_burst(32'h20, 8'd0, 2'b01, 0, 1'b0, -1);
        total++;
        if (b_resp !== 2'b00) begin bad++; $display("FAIL strobe_bresp got=%b exp=00", b_resp); end
        read_burst(32'h20, 8'd0, 2'b01, 1'b0);
        total++;
        if (rd_data[0] !== 32'hAABB_1234 || rd_last[0] !== 1'b1) begin
            bad++; $display("FAIL strobe_rdata got=%h/%b exp=aabb1234/1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hD000_0000 + i; wr_strb[i] = 4'hF; end
        write_burst(32'h08, 8'd3, 2'b10, 3, 1'b0, -1);
        total++;
        if (b_resp !== 2'b00) begin bad++; $display("FAIL wrap_bresp got=%b exp=00", b_resp); end
        // Beats landed at 0x08, 0x0C, 0x00, 0x04.
        exp_d[0] = 32'hD000_0002; exp_d[1] = 32'hD000_0003;
        exp_d[2] = 32'hD000_0000; exp_d[3] = 32'hD000_0001;
        read_burst(32'h00, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== exp_d[i]) begin
                bad++; $display("FAIL wrap_incr_read[%0d] got=%h exp=%h", i, rd_data[i], exp_d[i]);
            end
        end
        read_burst(32'h08, 8'd3, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'hD000_0000 + i || rd_resp[i] !== 2'b00) begin
                bad++; $display("FAIL wrap_wrap_read[%0d] got=%h/%b exp=%h/00", i, rd_data[i],
                                rd_resp[i], 32'hD000_0000 + i);
            end
        end
    endtask

    task automatic test_errors();
        read_burst(32'h0000_1000, 8'd1, 2'b01, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 1)) begin
                bad++; $display("FAIL oor_read[%0d] got=%h/%b/%b exp=0/10/%b", i, rd_data[i],
                                rd_resp[i], rd_last[i], (i == 1));
            end
        end
        wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
        write_burst(32'h10, 8'd0, 2'b11, 0, 1'b0, -1);
        total++;
        if (b_resp !== 2'b10) begin bad++; $display("FAIL rsvd_bresp got=%b exp=10", b_resp); end
        read_burst(32'h10, 8'd0, 2'b01, 1'b0);
        total++;
        if (rd_data[0] !== 32'h11) begin bad++; $display("FAIL rsvd_mem got=%h exp=00000011", rd_data[0]); end
        for (int i = 0; i < 3; i++) begin wr_data[i] = 32'hEEEE_0000 + i; wr_strb[i] = 4'hF; end
        write_burst(32'h14, 8'd2, 2'b10, 2, 1'b0, -1);
        total++;
        if (b_resp !== 2'b10) begin bad++; $display("FAIL wrap_len_bresp got=%b exp=10", b_resp); end
        read_burst(32'h14, 8'd0, 2'b01, 1'b0);
        total++;
        if (rd_data[0] !== 32'h22) begin bad++; $display("FAIL wrap_len_mem got=%h exp=00000022", rd_data[0]); end
        write_burst(32'h0000_1000, 8'd0, 2'b01, 0, 1'b0, -1);
        total++;
        if (b_resp !== 2'b10) begin bad++; $display("FAIL oor_bresp got=%b exp=10", b_resp); end
        write_burst(32'h40, 8'd3, 2'b01, 2, 1'b0, -1);
        total++;
        if (b_resp !== 2'b10) begin bad++; $display("FAIL early_wlast_bresp got=%b exp=10", b_resp); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin wr_data[i] = 32'hC000_0000 + i; wr_strb[i] = 4'hF; end
        write_burst(32'h100, 8'd7, 2'b01, 7, 1'b0, -1);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hE000_0000 + i;
        write_burst(32'h100, 8'd3, 2'b01, 3, 1'b1, -1);
        total++;
        if (b_resp !== 2'b00) begin bad++; $display("FAIL stall_bresp got=%b exp=00", b_resp); end
        read_burst(32'h100, 8'd7, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rd_data[i] !== ((i < 4) ? 32'hE000_0000 + i : 32'hC000_0000 + i) ||
                rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 7)) begin
                bad++; $display("FAIL stall_rbeat[%0d] got=%h/%b/%b", i, rd_data[i], rd_resp[i], rd_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA000_0000 + i; wr_strb[i] = 4'hF; end
        write_burst(32'h200, 8'd3, 2'b01, 3, 1'b0, -1);
        read_burst(32'h200, 8'd0, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hB000_0000 + i;
        write_burst(32'h200, 8'd3, 2'b01, 3, 1'b0, 2);
        aresetn = 1'b0;
        #1;
        total++;
        if ({axi_if.awready, axi_if.wready, axi_if.bvalid, axi_if.arready, axi_if.rvalid,
             axi_if.rlast, axi_if.bresp, axi_if.rresp, axi_if.rdata} !== 42'h0) begin
            bad++; $display("FAIL midreset_outputs got=wready%b rdata%h exp=all_zero",
                            axi_if.wready, axi_if.rdata);
        end
        axi_if.wvalid = 1'b0;
        axi_if.wlast  = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        read_burst(32'h200, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== ((i < 2) ? 32'hB000_0000 + i : 32'hA000_0000 + i)) begin
                bad++; $display("FAIL midreset_mem[%0d] got=%h", i, rd_data[i]);
            end
        end
    endtask

    initial begin
        axi_if.awaddr  = 32'h0; axi_if.awlen = 8'd0; axi_if.awburst = 2'b01; axi_if.awvalid = 1'b0;
        axi_if.wdata   = 32'h0; axi_if.wstrb = 4'h0; axi_if.wlast = 1'b0; axi_if.wvalid = 1'b0;
        axi_if.bready  = 1'b0;
        axi_if.araddr  = 32'h0; axi_if.arlen = 8'd0; axi_if.arburst = 2'b01; axi_if.arvalid = 1'b0;
        axi_if.rready  = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ei_axi4_slave_mem.md
Name: ei_axi4_slave_mem

Overview:
- Synthesizable AXI4 slave responder with internal word-addressed memory; the responding end that the VIP master agent drives.
- Instantiated in the testbench top, bound to the master interface signals.
- Gives the master, monitor and scoreboard a real, protocol-correct responder.
- Independent write and read channels; one outstanding burst per direction; FIXED, INCR and WRAP bursts; full-width transfers only.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width in bits: 32 or 64.
- MEM_DEPTH, 1024, memory size in DATA_WIDTH words.
- BASE_ADDR, 0, byte address of memory word 0.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write burst start address.
- awlen  in  8  beats minus 1.
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- awvalid/awready  in/out  1  AW handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- wlast  in  1  last write beat.
- wvalid/wready  in/out  1  W handshake.
- bresp  out  2  00 OKAY, 10 SLVERR.
- bvalid/bready  out/in  1  B handshake.
- araddr  in  ADDR_WIDTH  read burst start address.
- arlen  in  8  beats minus 1.
- arburst  in  2  same encoding as awburst.
- arvalid/arready  in/out  1  AR handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  per-beat response.
- rlast  out  1  last read beat.
- rvalid/rready  out/in  1  R handshake.

Behaviour:
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp = 00; rdata = 0.
  - awready and arready rise on the first aclk edge after aresetn deasserts.
  - Memory contents are not reset.
- Reset mid-burst: outputs go to reset values immediately and the FSMs return to IDLE. The partial burst is discarded; beats already written remain in memory.
- Address arithmetic (B = DATA_WIDTH/8):
  - Addresses are aligned down to B.
  - FIXED: address is constant. INCR: address += B per beat.
  - WRAP: len+1 must be 2, 4, 8 or 16 and the start address must be aligned to B; otherwise the burst is an error burst.
  - WRAP window = (len+1)*B; lower bound = addr rounded down to the window; address wraps to the lower bound on reaching lower bound + window.
  - Word index = (addr - BASE_ADDR)/B. A beat is out of range if addr < BASE_ADDR or index >= MEM_DEPTH.
- Write FSM: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&&awready, latch addr/len/burst, clear the beat counter and error flag, then go to W_DATA with awready=0 and wready=1.
  - W_DATA: each wvalid&&wready writes the bytes enabled by wstrb at the current address, then the address advances.
  - No memory write occurs for a beat that is out of range or belongs to an error burst (reserved burst or illegal WRAP); such a beat sets the error flag.
  - wlast on a beat other than beat len, or beat len without wlast, sets the error flag.
  - The burst ends on the wlast handshake, or after 256 beats if wlast never arrives. The FSM then goes to W_RESP with wready=0.
  - W_RESP: bvalid=1; bresp=10 if the error flag is set, else 00. bvalid and bresp hold until bready, then the FSM returns to W_IDLE.
  - Minimum AW-to-B latency = len+2 cycles.
- Read FSM: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On handshake, latch the request, register beat 0 into rdata/rresp, and set rlast=(len==0). rvalid=1 on the next cycle (1-cycle latency).
  - R_DATA: rdata, rresp and rlast hold stable while rvalid && !rready.
  - On rvalid&&rready: if rlast, go to R_IDLE with rvalid=0; otherwise register the next beat, with no bubble cycle.
  - Out-of-range beat or error burst: rdata=0, rresp=10.
- Simultaneous events:
  - Read and write channels run fully concurrently.
  - A write and a read-beat load to the same word on the same edge: the read returns the pre-write data.
  - AW and W arriving in the same cycle: W is not accepted until W_DATA (wready=0 in W_IDLE).
- 4KB boundary crossing is not checked (VIP checker responsibility).

Test Plan:
- Reset, then INCR write awaddr=0x10, awlen=3, wdata 0x11,0x22,0x33,0x44, wstrb=0xF -> bresp=00; INCR read of the same range returns 0x11..0x44 in order, rlast on beat 3 only, rresp=00.
- Write 0xAABBCCDD to 0x20, then write wstrb=0x3, wdata=0x00001234 -> read 0x20 returns 0xAABB1234.
- WRAP write awaddr=0x08, awlen=3 (window 0x00-0x0F), data D0..D3 -> read INCR from 0x00 returns D2,D3,D0,D1.
- Read araddr=BASE_ADDR+MEM_DEPTH*4, arlen=1 -> two beats, rdata=0, rresp=10. Write with awburst=11 -> bresp=10 and memory unchanged.
- Randomly toggle rready/bready during an 8-beat read and a 4-beat write -> no data lost, outputs stable while stalled; wlast on beat 2 of awlen=3 -> bresp=10.
- Assert aresetn=0 mid-way through a 4-beat write (after 2 beats) -> all outputs 0 immediately; after release, reading the addresses shows beats 0-1 written, beats 2-3 unchanged.
